// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and mul/div structural stalls, taken-branch flushes,
// and the mul/div occupancy FSM that sequences the HI/LO write-back strobe.
module hazard_ctrl #(
    parameter int unsigned ADDR_WIDTH    = 5,
    parameter int unsigned MULDIV_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] reg_s_addr_id,
    input  logic [ADDR_WIDTH-1:0] reg_t_addr_id,
    input  logic                  reg_s_re_id,
    input  logic                  reg_t_re_id,
    input  logic                  mem_read_ex,
    input  logic [ADDR_WIDTH-1:0] reg_d_addr_ex,
    input  logic                  muldiv_id,
    input  logic                  hilo_read_id,
    input  logic                  muldiv_start_ex,
    input  logic                  branch_taken_ex,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  muldiv_busy,
    output logic                  hilo_we
);

    localparam int unsigned CntW = $clog2(MULDIV_CYCLES + 1);
    localparam logic [CntW-1:0] CntReload = CntW'(MULDIV_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            load_use;
    logic            md_stall;
    logic            stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // BUSY counts down from MULDIV_CYCLES-1 to 0, so it lasts exactly MULDIV_CYCLES cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (muldiv_start_ex) begin
                    state_d = StBusy;
                    cnt_d   = CntReload;
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                if (muldiv_start_ex) begin
                    state_d = StBusy;
                    cnt_d   = CntReload;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign muldiv_busy = (state_q == StBusy);
    assign hilo_we     = (state_q == StDone);

    always_comb begin
        load_use = mem_read_ex && (reg_d_addr_ex != '0) &&
                   ((reg_s_re_id && (reg_s_addr_id == reg_d_addr_ex)) ||
                    (reg_t_re_id && (reg_t_addr_id == reg_d_addr_ex)));
        // HI/LO is written at the end of DONE, before the ID op reaches EX, so DONE needs no stall.
        md_stall = (muldiv_id || hilo_read_id) && ((state_q == StBusy) || muldiv_start_ex);
        stall    = load_use || md_stall;
    end

    // A taken branch kills the ID instruction, so flush wins over stall.
    assign pc_stall    = stall && !branch_taken_ex;
    assign if_id_stall = stall && !branch_taken_ex;
    assign if_id_flush = branch_taken_ex;
    assign id_ex_flush = stall || branch_taken_ex;

endmodule
